// File: rtl/demux12_buf.sv
// Registered 1-to-12 one-hot/multicast demultiplexer with a single-entry buffer per channel.
// Upstream accepts a word only when every selected channel can take it in the same cycle.
module demux12_buf #(
    parameter int unsigned DW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_sel,
    input  logic [DW-1:0]    in_data,
    output logic [11:0]      out_valid,
    input  logic [11:0]      out_ready,
    output logic [12*DW-1:0] out_data,
    output logic             err
);

    logic [11:0]          valid_q, valid_d;
    logic [11:0][DW-1:0]  data_q, data_d;
    logic                 err_q, err_d;

    logic [11:0] can_take;
    logic [11:0] push;
    logic [11:0] pop;
    logic        accept;

    assign can_take = ~valid_q | out_ready;
    // Ready never looks at in_valid; held low during reset so nothing is taken.
    assign in_ready = ~reset & (&(~in_sel | can_take));
    assign accept   = in_valid & in_ready;
    assign push     = {12{accept}} & in_sel;
    assign pop      = valid_q & out_ready;

    always_comb begin
        valid_d = (valid_q & ~pop) | push;
        data_d  = data_q;
        for (int i = 0; i < 12; i++) begin
            if (push[i]) begin
                data_d[i] = in_data;
            end
        end
        err_d = err_q | (accept & (in_sel == 12'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_demux12_buf.sv
// Scoreboard bench for demux12_buf (DW=8): stimulus pushes expected words per channel,
// a monitor pops and compares on every output handshake.
module tb_demux12_buf;

    localparam int unsigned DW = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_sel;
    logic [DW-1:0]    in_data;
    logic [11:0]      out_valid;
    logic [11:0]      out_ready;
    logic [12*DW-1:0] out_data;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbq [12][$];

    demux12_buf #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so at negedge a visible handshake
    // is exactly the one that completes at the next posedge.
    always @(negedge clk) begin
        for (int i = 0; i < 12; i++) begin
            if (!reset && out_valid[i] && out_ready[i]) begin
                checks++;
                if (sbq[i].size() == 0) begin
                    errors++;
                    $display("FAIL pop_ch%0d: got data %h, expected no word", i,
                             out_data[i*DW +: DW]);
                end else begin
                    logic [7:0] exp;
                    exp = sbq[i].pop_front();
                    if (out_data[i*DW +: DW] !== exp) begin
                        errors++;
                        $display("FAIL pop_ch%0d: got data %h, expected %h", i,
                                 out_data[i*DW +: DW], exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and move to the sampling point of that cycle.
    task automatic step(input logic v, input logic [11:0] sel, input logic [7:0] d,
                        input logic [11:0] ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
    endtask

    // Check in_ready against the hand expectation; queue the word if it should be taken.
    task automatic expect_ready(input string name, input logic exp);
        check(name, {31'd0, in_ready}, {31'd0, exp});
        if (exp && in_valid) begin
            for (int i = 0; i < 12; i++) begin
                if (in_sel[i]) sbq[i].push_back(in_data);
            end
        end
    endtask

    function automatic logic [7:0] chdata(input int i);
        return out_data[i*DW +: DW];
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {20'd0, out_valid}, 32'h0);
        check("reset_err", {31'd0, err}, 32'h0);
        check("reset_data", out_data[31:0], 32'h0);
        check("idle_in_ready", {31'd0, in_ready}, 32'h1);

        // Single word to channel 0.
        step(1'b1, 12'h001, 8'hA5, 12'hFFF);
        expect_ready("t1_ready", 1'b1);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t1_valid", {20'd0, out_valid}, 32'h001);
        check("t1_data", {24'd0, chdata(0)}, 32'hA5);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t1_drain", {20'd0, out_valid}, 32'h000);

        // Streaming to channel 5.
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 12'h020, 8'(k), 12'hFFF);
            expect_ready("t2_ready", 1'b1);
            if (k > 1) check("t2_data", {24'd0, chdata(5)}, k - 1);
        end
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t2_drain", {20'd0, out_valid}, 32'h000);

        // Multicast blocked by full channel 6.
        step(1'b1, 12'h040, 8'h66, 12'h000);
        expect_ready("t3_fill6", 1'b1);
        step(1'b1, 12'h0C3, 8'h77, 12'h000);
        expect_ready("t3_blocked", 1'b0);
        check("t3_valid_blocked", {20'd0, out_valid}, 32'h040);
        step(1'b1, 12'h0C3, 8'h77, 12'h000);
        expect_ready("t3_blocked2", 1'b0);
        check("t3_ch6_hold", {24'd0, chdata(6)}, 32'h66);
        step(1'b1, 12'h0C3, 8'h77, 12'h040);
        expect_ready("t3_release", 1'b1);
        step(1'b0, 12'h000, 8'h00, 12'h000);
        check("t3_multicast_valid", {20'd0, out_valid}, 32'h0C3);
        check("t3_ch1_data", {24'd0, chdata(1)}, 32'h77);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t3_drain", {20'd0, out_valid}, 32'h000);

        // Full channel 3 does not block a word for channel 4.
        step(1'b1, 12'h008, 8'h33, 12'h000);
        expect_ready("t4_fill3", 1'b1);
        step(1'b1, 12'h010, 8'h44, 12'h000);
        expect_ready("t4_ch4", 1'b1);
        step(1'b0, 12'h000, 8'h00, 12'h000);
        check("t4_valid", {20'd0, out_valid}, 32'h018);
        check("t4_ch3_data", {24'd0, chdata(3)}, 32'h33);
        check("t4_ch4_data", {24'd0, chdata(4)}, 32'h44);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);

        // Empty select: accepted, dropped, sticky err.
        step(1'b1, 12'h000, 8'h99, 12'hFFF);
        expect_ready("t5_ready", 1'b1);
        check("t5_err_before", {31'd0, err}, 32'h0);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t5_valid", {20'd0, out_valid}, 32'h000);
        check("t5_err", {31'd0, err}, 32'h1);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t5_err_sticky", {31'd0, err}, 32'h1);

        // Fill all channels, check all-12 blocking, then reset.
        step(1'b1, 12'hFFF, 8'hC0, 12'h000);
        expect_ready("t6_fill", 1'b1);
        step(1'b1, 12'hFFF, 8'hC1, 12'h000);
        expect_ready("t6_all_blocked", 1'b0);
        step(1'b1, 12'hFFF, 8'hC1, 12'h7FF);
        expect_ready("t6_one_blocks", 1'b0);
        check("t6_ch11_hold", {24'd0, chdata(11)}, 32'hC0);
        // Channels 0..10 pop C0 this cycle; refill them before reset.
        step(1'b1, 12'h7FF, 8'hC2, 12'h000);
        expect_ready("t6_refill", 1'b1);
        step(1'b1, 12'h001, 8'hC3, 12'h000);
        check("t6_full_valid", {20'd0, out_valid}, 32'hFFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_ready_in_reset", {31'd0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) sbq[i].delete();
        @(negedge clk);
        check("t6_valid_after", {20'd0, out_valid}, 32'h000);
        check("t6_data_after", out_data[95:64] | out_data[63:32] | out_data[31:0], 32'h0);
        check("t6_err_after", {31'd0, err}, 32'h0);
        check("t6_ready_after", {31'd0, in_ready}, 32'h1);

        // All 12 selected with every consumer ready.
        step(1'b1, 12'hFFF, 8'h5A, 12'hFFF);
        expect_ready("t7_all", 1'b1);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t7_valid", {20'd0, out_valid}, 32'hFFF);
        step(1'b0, 12'h000, 8'h00, 12'hFFF);
        check("t7_drain", {20'd0, out_valid}, 32'h000);

        for (int i = 0; i < 12; i++) begin
            check("sb_empty", sbq[i].size(), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux12_buf.md
# demux12_buf

Registered 1-to-12 one-hot demultiplexer with per-channel single-entry output buffers and valid/ready flow control. It is the fan-out counterpart of the 12-way one-hot AND-OR mux. One upstream stream is steered, or multicast, to any subset of 12 downstream consumers using the same one-hot select convention. It sits between a single producer and up to 12 independently back-pressured sinks.

## Interface
Parameters:
- DW, 1, data width per channel

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted when in_valid & in_ready
- in_sel  in  12  one-hot/multi-hot destination mask; bit i = channel i
- in_data  in  DW  upstream data
- out_valid  out  12  channel i holds a word
- out_ready  in  12  channel i consumer accepts
- out_data  out  12*DW  channel i data at [i*DW +: DW]
- err  out  1  sticky: a word was accepted with in_sel == 0

## Operation
- Each channel i has one buffer entry: valid_q[i], data_q[i].
- can_take[i] = ~valid_q[i] | out_ready[i].
- in_ready = AND over i of (~in_sel[i] | can_take[i]). Multicast is all-or-nothing: a word is accepted only when every selected channel can take it in the same cycle.
- accept = in_valid & in_ready; push[i] = accept & in_sel[i].
- pop[i] = valid_q[i] & out_ready[i].
- Channel update:
  - push[i]: valid_q[i] <= 1, data_q[i] <= in_data.
  - pop[i] & ~push[i]: valid_q[i] <= 0.
  - Push and pop together: the old word leaves, the new word loads, and valid stays 1.
- Unselected channels are never disturbed by an accept.
- in_sel == 0 with in_valid: in_ready = 1. The word is accepted and discarded, and err <= 1. err clears only on reset.
- out_valid = valid_q; out_data = data_q concatenation.
- in_ready depends combinationally on out_ready and in_sel. in_ready must not depend on in_valid.

## Timing
- Reset (reset high at an edge): valid_q = 0 for all channels, data_q = 0, err = 0.
- While reset is asserted, in_ready is forced to 0 and no word is accepted.
- Reset asserted mid-transfer drops all buffered words with no partial state retained.
- Latency: a word accepted at edge N appears on out_valid/out_data of the selected channels after edge N and is visible in cycle N+1.
- Throughput: 1 word/cycle per channel when the consumer holds out_ready high (push+pop same edge).
- out_data[i] is stable while out_valid[i] & ~out_ready[i]. The channel output follows valid/ready hold rules.
- Boundary conditions:
  - Full channel with out_ready low blocks any word selecting it. Other channels are unaffected only if not selected.
  - All 12 selected: accepted only when all 12 can take.
  - in_sel changing while in_valid is high and in_ready is low is legal. The decision each cycle uses the current in_sel.

## Test plan
- Reset, then in_valid=1, in_sel=12'h001, in_data=8'hA5 (DW=8), out_ready=all 1 -> out_valid=12'h001 next cycle, out_data[7:0]=A5, then out_valid=0 after one more cycle with no new input.
- Streaming to channel 5 with out_ready[5]=1, data 1,2,3,... every cycle -> in_ready stays 1, channel 5 outputs 1,2,3 in order, one per cycle, 1-cycle latency.
- Multicast in_sel=12'h0C3, channel 6 full with out_ready[6]=0 -> in_ready=0 and channels 0,1,7 get nothing. Raise out_ready[6] -> word accepted and lands on channels 0,1,6,7 simultaneously.
- Channel 3 full with out_ready[3]=0; send to in_sel=12'h010 -> accepted, channel 4 loads, and channel 3 data and valid are unchanged.
- in_valid=1 with in_sel=0 -> in_ready=1, all out_valid stay 0, err=1 next cycle and stays 1 until reset.
- Fill channels 0..11, assert reset for one cycle -> out_valid=0, out_data=0, err=0, in_ready=0 during reset, in_ready=1 afterwards.
